// File: rtl/config_chain_loader_pkg.sv
// rtl/config_chain_loader_pkg.sv - shared state type and helpers for the config chain loader
package cfg_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SET,
    DONE
  } state_e;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/config_chain_loader_if.sv
// rtl/config_chain_loader_if.sv - valid/ready word stream feeding the config chain loader
interface config_chain_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/config_chain_loader_serializer.sv
// rtl/config_chain_loader_serializer.sv - word buffer that releases its bits LSB-first
module cfg_word_serializer #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_bits,
  input  logic              shift_en,
  output logic              empty,
  output logic              last_bit,
  output logic              bit0
);

  logic [WORD_W-1:0] wsr_q, wsr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // A load may coincide with consuming the final buffered bit; the new word replaces it.
  always_comb begin
    wsr_d = wsr_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (load) begin
      wsr_d = load_data;
      cnt_d = load_bits;
    end else if (shift_en && (cnt_q != '0)) begin
      wsr_d = wsr_q >> 1;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wsr_q <= '0;
      cnt_q <= '0;
    end else begin
      wsr_q <= wsr_d;
      cnt_q <= cnt_d;
    end
  end

  assign empty    = (cnt_q == '0);
  assign last_bit = (cnt_q == CNT_W'(1));
  assign bit0     = wsr_q[0];

endmodule

// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - streams config words LSB-first into a tile shift chain, then strobes set
module config_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int CHAIN_LEN  = 48,
  parameter int WORD_W     = 32,
  parameter int SET_CYCLES = 2,
  localparam int BL_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  config_chain_loader_if.slave  s_in,
  output logic                  cfg_cen,
  output logic                  cfg_shift_out,
  output logic                  cfg_set,
  output logic                  busy,
  output logic                  done,
  output logic [BL_W-1:0]       bits_left
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int SC_W  = $clog2(SET_CYCLES + 1);

  state_e            state_q, state_d;
  logic [BL_W-1:0]   bits_left_q, bits_left_d;
  logic [SC_W-1:0]   set_cnt_q, set_cnt_d;
  logic              cen_q, cen_d;
  logic              so_q, so_d;

  logic              ser_empty, ser_last, ser_bit0;
  logic              flush, load, in_ready;
  logic [CNT_W-1:0]  load_bits;
  int unsigned       need;

  // Bits still owed to the chain that are not yet sitting in the buffer after this cycle.
  always_comb begin
    need      = 32'(bits_left_q) - (ser_last ? 32'd1 : 32'd0);
    in_ready  = (state_q == SHIFT) && (ser_empty || ser_last) && (need != 0);
    load      = in_ready && s_in.in_valid;
    load_bits = CNT_W'(min_u(WORD_W, need));
  end

  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    set_cnt_d   = set_cnt_q;
    cen_d       = 1'b0;
    so_d        = 1'b0;
    flush       = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = SHIFT;
          bits_left_d = BL_W'(CHAIN_LEN);
          flush       = 1'b1;
        end
      end
      SHIFT: begin
        if (bits_left_q == '0) begin
          state_d   = SET;
          set_cnt_d = '0;
        end else if (!ser_empty) begin
          cen_d       = 1'b1;
          so_d        = ser_bit0;
          bits_left_d = bits_left_q - BL_W'(1);
        end
      end
      SET: begin
        if (set_cnt_q == SC_W'(SET_CYCLES - 1)) begin
          state_d = DONE;
        end else begin
          set_cnt_d = set_cnt_q + SC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bits_left_q <= '0;
      set_cnt_q   <= '0;
      cen_q       <= 1'b0;
      so_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      set_cnt_q   <= set_cnt_d;
      cen_q       <= cen_d;
      so_q        <= so_d;
    end
  end

  cfg_word_serializer #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .load      (load),
    .load_data (s_in.in_data),
    .load_bits (load_bits),
    .shift_en  (state_q == SHIFT),
    .empty     (ser_empty),
    .last_bit  (ser_last),
    .bit0      (ser_bit0)
  );

  assign s_in.in_ready = in_ready;
  assign cfg_cen       = cen_q;
  assign cfg_shift_out = so_q;
  assign cfg_set       = (state_q == SET);
  assign busy          = (state_q == SHIFT) || (state_q == SET);
  assign done          = (state_q == DONE);
  assign bits_left     = bits_left_q;

endmodule
